shift_chain_tx: RTL and testbench

SHIFT_CHAIN_TX -- requirements
Module: shift_chain_tx

---
 rtl/shift_chain_tx.sv | 154 +++++++++++++++
 tb/tb_shift_chain_tx.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_chain_tx.sv
// -----------------------------------------------------------------------------
// shift_chain_tx
//
// Serialises a WIDTH-bit parallel word into a downstream chain of 74HC194-style
// universal shift registers. The block drives the chain's serial input (DS)
// and its mode pins (S), then pulses done once every bit has been shifted in.
// When the transfer ends the chain holds the word unmodified.
//
// Parameters
//   WIDTH  word length in bits and length of the downstream chain (2..32)
//
// Ports
//   CP     in   clock, all state changes on its rising edge
//   CR_n   in   synchronous active-low reset; also forces S=00 while low
//   D      in   [WIDTH-1:0] parallel word, captured on acceptance
//   load   in   transfer request, accepted when load && ready at a CP edge
//   dir    in   0 = right shift (LSB first), 1 = left shift (MSB first)
//   ready  out  idle and able to accept a word
//   DS     out  serial data for the chain
//   S      out  [1:0] chain mode: 00 hold, 01 shift right, 10 shift left
//   done   out  one-cycle pulse after the last shift
//
// Build option
//   SHIFT_CHAIN_TX_PARITY_EN  when defined, a PAR cycle follows the data bits
//                             and shifts the even parity (XOR) of the word
//                             into the chain; done moves one cycle later.
// -----------------------------------------------------------------------------
module shift_chain_tx #(
    parameter int WIDTH = 8
) (
    input  logic             CP,
    input  logic             CR_n,
    input  logic [WIDTH-1:0] D,
    input  logic             load,
    input  logic             dir,
    output logic             ready,
    output logic             DS,
    output logic [1:0]       S,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
`ifdef SHIFT_CHAIN_TX_PARITY_EN
    localparam logic [1:0] ST_PAR   = 2'd3;
`endif

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SR   = 2'b01;
    localparam logic [1:0] MODE_SL   = 2'b10;

    logic [1:0]       state;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] word;
    logic             dir_q;
    logic [1:0]       s_q;
    logic             ds_q;
    logic             done_q;
    logic             ready_q;

    logic [CW-1:0]    next_idx;
    logic             next_bit;

    // DS is registered, so the bit for the following cycle is selected one
    // cycle ahead: index bit_cnt+1 counted from the LSB (dir=0) or MSB (dir=1).
    always_comb begin
        next_idx = bit_cnt + CW'(1);
        next_bit = dir_q ? word[CW'(WIDTH-1) - next_idx] : word[next_idx];
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CP) begin
        if (!CR_n) begin
            // NOTE: the captured word is cleared on reset as well, so the
            // block comes out of reset in a fully defined state.
            state   <= ST_IDLE;
            bit_cnt <= '0;
            word    <= '0;
            dir_q   <= 1'b0;
            s_q     <= MODE_HOLD;
            ds_q    <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        // First bit goes out in the very first SHIFT cycle so
                        // the chain's first sampling edge already sees it.
                        word    <= D;
                        dir_q   <= dir;
                        bit_cnt <= '0;
                        ds_q    <= dir ? D[WIDTH-1] : D[0];
                        s_q     <= dir ? MODE_SL : MODE_SR;
                        ready_q <= 1'b0;
                        state   <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (bit_cnt == CW'(WIDTH-1)) begin
`ifdef SHIFT_CHAIN_TX_PARITY_EN
                        // Mode stays as is: the chain takes one more shift.
                        ds_q  <= ^word;
                        state <= ST_PAR;
`else
                        s_q    <= MODE_HOLD;
                        ds_q   <= 1'b0;
                        done_q <= 1'b1;
                        state  <= ST_DONE;
`endif
                    end else begin
                        bit_cnt <= next_idx;
                        ds_q    <= next_bit;
                    end
                end

`ifdef SHIFT_CHAIN_TX_PARITY_EN
                ST_PAR: begin
                    s_q    <= MODE_HOLD;
                    ds_q   <= 1'b0;
                    done_q <= 1'b1;
                    state  <= ST_DONE;
                end
`endif

                ST_DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= ST_IDLE;
                end

                default: begin
                    s_q     <= MODE_HOLD;
                    ds_q    <= 1'b0;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    // The chain must hold while reset is asserted, before the reset edge.
    assign S     = CR_n ? s_q : MODE_HOLD;
    assign DS    = ds_q;
    assign done  = done_q;
    assign ready = ready_q;

endmodule

// File: tb/tb_shift_chain_tx.sv
// -----------------------------------------------------------------------------
// tb_shift_chain_tx
//
// Bench for shift_chain_tx with WIDTH=8. DS/S drive a behavioural 74HC194
// chain model. A transaction-level model (cycles since acceptance) predicts
// every output each cycle; the chain contents are compared on every done.
// Directed scenarios pin the model with hand-computed literals, then a
// randomized phase with loads, direction changes and resets follows.
// Honours SHIFT_CHAIN_TX_PARITY_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_shift_chain_tx;

    localparam int W = 8;
`ifdef SHIFT_CHAIN_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    // Cycle index (1 = first cycle after acceptance) of the done cycle.
    localparam int LAST = W + P + 1;

    logic         CP   = 1'b0;
    logic         CR_n = 1'b0;
    logic [W-1:0] D    = '0;
    logic         load = 1'b0;
    logic         dir  = 1'b0;
    logic         ready;
    logic         DS;
    logic [1:0]   S;
    logic         done;

    int errors = 0;
    int checks = 0;

    shift_chain_tx #(.WIDTH(W)) dut (
        .CP    (CP),
        .CR_n  (CR_n),
        .D     (D),
        .load  (load),
        .dir   (dir),
        .ready (ready),
        .DS    (DS),
        .S     (S),
        .done  (done)
    );

    always #5 CP = ~CP;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- 74HC194 chain: right shift enters at the MSB end -------
    logic [W-1:0] chain_q = '0;
    always @(posedge CP) begin
        case (S)
            2'b01:   chain_q <= {DS, chain_q[W-1:1]};
            2'b10:   chain_q <= {chain_q[W-2:0], DS};
            default: chain_q <= chain_q;
        endcase
    end

    function automatic logic [W-1:0] exp_chain(input logic [W-1:0] w, input logic d);
        logic p;
        p = ^w;
        if (P == 0) return w;
        return d ? {w[W-2:0], p} : {p, w[W-1:1]};
    endfunction

    // ---------------- Transaction model: n = cycles since acceptance ----------
    int           n      = 0;
    logic [W-1:0] mw     = '0;
    logic         md     = 1'b0;
    bit           mvalid = 1'b0;

    always @(posedge CP) begin
        if (!CR_n) begin
            n      = 0;
            mvalid = 1'b1;
        end else if (n == 0) begin
            if (load) begin
                n  = 1;
                mw = D;
                md = dir;
            end
        end else if (n == LAST) begin
            n = 0;
        end else begin
            n = n + 1;
        end
    end

    // ---------------- Per-cycle compare ---------------------------------------
    always @(negedge CP) begin : cmp
        logic [1:0] es;
        logic       eds, erdy, edn;
        bit         chk_ds;
        if (mvalid) begin
            es = 2'b00; eds = 1'b0; erdy = 1'b0; edn = 1'b0; chk_ds = 1'b1;
            if (n == 0) begin
                erdy = 1'b1;
            end else if (n <= W) begin
                es  = md ? 2'b10 : 2'b01;
                eds = md ? mw[W-n] : mw[n-1];
            end else if (n < LAST) begin
                es  = md ? 2'b10 : 2'b01;
                eds = ^mw;
            end else begin
                edn    = 1'b1;
                chk_ds = 1'b0;
            end
            if (!CR_n) es = 2'b00;
            check("S", S, es);
            check("ready", ready, erdy);
            check("done", done, edn);
            if (chk_ds) check("DS", DS, eds);
            if (done) check("chain_q", chain_q, exp_chain(mw, md));
        end
    end

    // ---------------- Directed helpers ----------------------------------------
    task automatic wait_ready();
        for (int i = 0; i < 40; i++) begin
            @(posedge CP); #2;
            if (ready) return;
        end
        check("ready_timeout", 0, 1);
    endtask

    // One complete transfer; reports shift-cycle count, the cycle index of
    // done and of ready returning, and the DS bits in shift order.
    task automatic xfer(input logic [W-1:0] d, input logic dr,
                        output int shifts, output int done_c, output int ready_c,
                        output logic [15:0] bits);
        shifts = 0; done_c = 0; ready_c = 0; bits = '0;
        wait_ready();
        D = d; dir = dr; load = 1'b1;
        @(posedge CP); #2;
        load = 1'b0; D = ~d; dir = ~dr;   // must not disturb the word in flight
        for (int c = 1; c <= 20; c++) begin
            @(negedge CP);
            if (S != 2'b00) begin
                if (shifts < 16) bits[shifts] = DS;
                shifts++;
            end
            if (done && done_c == 0) done_c = c;
            if (ready) begin
                ready_c = c;
                break;
            end
        end
        if (ready_c == 0) check("xfer_timeout", 0, 1);
    endtask

    int           sh, dc, rc, gap, dones;
    logic [15:0]  bits;
    logic [W-1:0] lit;

    initial begin
        // Reset
        CR_n = 1'b0;
        repeat (3) @(posedge CP);
        #2 CR_n = 1'b1;
        @(negedge CP);
        check("rst_ready", ready, 1);
        check("rst_S", S, 0);
        check("rst_DS", DS, 0);
        check("rst_done", done, 0);

        // 8'h1E right shift: DS 0,1,1,1,1,0,0,0
        xfer(8'h1E, 1'b0, sh, dc, rc, bits);
        check("t1_shifts", sh, W + P);
        check("t1_ds", bits[7:0], 8'h1E);
        check("t1_done_cycle", dc, W + P + 1);
        check("t1_ready_cycle", rc, W + P + 2);
`ifdef SHIFT_CHAIN_TX_PARITY_EN
        lit = 8'h0F;
`else
        lit = 8'h1E;
`endif
        check("t1_chain", chain_q, lit);

        // 8'h1E left shift: DS 0,0,0,1,1,1,1,0 -> packed 8'h78
        xfer(8'h1E, 1'b1, sh, dc, rc, bits);
        check("t2_shifts", sh, W + P);
        check("t2_ds", bits[7:0], 8'h78);
`ifdef SHIFT_CHAIN_TX_PARITY_EN
        lit = 8'h3C;
`else
        lit = 8'h1E;
`endif
        check("t2_chain", chain_q, lit);

        // 8'h07 right shift (parity of 8'h07 is 1)
        xfer(8'h07, 1'b0, sh, dc, rc, bits);
        check("t3_shifts", sh, W + P);
        check("t3_done_cycle", dc, W + P + 1);
`ifdef SHIFT_CHAIN_TX_PARITY_EN
        check("t3_parity_bit", bits[8], 1);
        lit = 8'h83;
`else
        lit = 8'h07;
`endif
        check("t3_chain", chain_q, lit);

        // load held high with 8'hFF while 8'h5A is in flight
        wait_ready();
        D = 8'h5A; dir = 1'b0; load = 1'b1;
        @(posedge CP); #2;
        D = 8'hFF;
        dones = 0; gap = 0;
        for (int c = 0; c < 30 && dones == 0; c++) begin
            @(negedge CP);
            if (done) dones++;
        end
        check("t4_first_done", dones, 1);
`ifdef SHIFT_CHAIN_TX_PARITY_EN
        lit = 8'h2D;
`else
        lit = 8'h5A;
`endif
        check("t4_chain_5a", chain_q, lit);
        // The DONE cycle plus the one IDLE cycle in which ready is high.
        gap = 1;
        for (int c = 0; c < 10 && S == 2'b00; c++) begin
            @(negedge CP);
            if (S == 2'b00) gap++;
        end
        check("t4_hold_gap", gap, 2);
        @(posedge CP); #2 load = 1'b0;
        dones = 0;
        for (int c = 0; c < 30 && dones == 0; c++) begin
            @(negedge CP);
            if (done) dones++;
        end
        check("t4_second_done", dones, 1);
`ifdef SHIFT_CHAIN_TX_PARITY_EN
        lit = 8'h7F;
`else
        lit = 8'hFF;
`endif
        check("t4_chain_ff", chain_q, lit);

        // Reset after 3 bits of 8'hA5
        wait_ready();
        D = 8'hA5; dir = 1'b0; load = 1'b1;
        @(posedge CP); #2 load = 1'b0;
        repeat (3) @(negedge CP);
        @(posedge CP); #2 CR_n = 1'b0;
        #1 check("t5_S_forced_hold", S, 0);
        @(posedge CP); #2 CR_n = 1'b1;
        check("t5_ready", ready, 1);
        check("t5_done", done, 0);
        check("t5_S", S, 0);
        xfer(8'h3C, 1'b0, sh, dc, rc, bits);
`ifdef SHIFT_CHAIN_TX_PARITY_EN
        lit = 8'h1E;
`else
        lit = 8'h3C;
`endif
        check("t5_chain", chain_q, lit);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            @(posedge CP); #2;
            CR_n = ($urandom_range(0, 63) != 0);
            load = ($urandom_range(0, 3) == 0);
            D    = W'($urandom);
            dir  = 1'($urandom_range(0, 1));
        end
        CR_n = 1'b1; load = 1'b0;
        repeat (W + 6) @(posedge CP);
        @(negedge CP);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
